buraq_multdiv_issue: RTL and testbench

Initiator-side controller for the slow multiply/divide unit. It accepts an RV32M request from the decoder, drives the multdiv control, operand and operator interface, and owns the two 34-bit intermediate-value registers the multdiv unit writes through. It holds the multdiv unit enabled until the unit reports valid, captures the result, and presents it to writeback with a valid/ready handshake. Kill requests are handled by draining the in-flight operation.

---
 rtl/buraq_multdiv_issue_pkg.sv | 36 +++
 rtl/buraq_multdiv_issue.sv | 170 +++++++++++++++++
 tb/tb_buraq_multdiv_issue.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/buraq_multdiv_issue_pkg.sv
// Shared types for the multiply/divide issue controller: multdiv operator
// encoding, RV32M funct3 codes and the issue FSM state encoding.
package buraq_multdiv_issue_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned IMD_W  = 34;
  localparam int unsigned RD_W   = 5;
  localparam int unsigned F3_W   = 3;

  // Operator presented to the multdiv unit.
  typedef enum logic [1:0] {
    MD_OP_MULL,
    MD_OP_MULH,
    MD_OP_DIV,
    MD_OP_REM
  } md_op_e;

  // RV32M funct3 encodings.
  localparam logic [F3_W-1:0] F3_MUL    = 3'b000;
  localparam logic [F3_W-1:0] F3_MULH   = 3'b001;
  localparam logic [F3_W-1:0] F3_MULHSU = 3'b010;
  localparam logic [F3_W-1:0] F3_MULHU  = 3'b011;
  localparam logic [F3_W-1:0] F3_DIV    = 3'b100;
  localparam logic [F3_W-1:0] F3_DIVU   = 3'b101;
  localparam logic [F3_W-1:0] F3_REM    = 3'b110;
  localparam logic [F3_W-1:0] F3_REMU   = 3'b111;

  // Issue controller states.
  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DRAIN,
    RESP
  } md_issue_fsm_e;

endpackage

// File: rtl/buraq_multdiv_issue.sv
// Initiator-side controller for the slow multiply/divide unit.
// Accepts an RV32M request (req_*), latches operands/funct3/rd, drives the
// multdiv enables, selects, operator and signedness, owns the two 34-bit
// intermediate registers (imd_val_*), and returns the result to writeback
// through a valid/ready handshake (wb_*). kill_i drains an in-flight op.
// WbBypass=1 forwards the result to writeback in the multdiv valid cycle.
module buraq_multdiv_issue
  import buraq_multdiv_issue_pkg::*;
#(
  parameter bit WbBypass = 1'b0
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        req_valid_i,
  output logic                        req_ready_o,
  input  logic [F3_W-1:0]             req_funct3_i,
  input  logic [XLEN-1:0]             req_op_a_i,
  input  logic [XLEN-1:0]             req_op_b_i,
  input  logic [RD_W-1:0]             req_rd_i,
  input  logic                        kill_i,
  input  logic                        data_ind_timing_i,
  output logic                        mult_en_o,
  output logic                        div_en_o,
  output logic                        mult_sel_o,
  output logic                        div_sel_o,
  output md_op_e                      operator_o,
  output logic [1:0]                  signed_mode_o,
  output logic [XLEN-1:0]             op_a_o,
  output logic [XLEN-1:0]             op_b_o,
  output logic [1:0][IMD_W-1:0]       imd_val_q_o,
  input  logic [1:0][IMD_W-1:0]       imd_val_d_i,
  input  logic [1:0]                  imd_val_we_i,
  output logic                        multdiv_ready_id_o,
  input  logic [XLEN-1:0]             multdiv_result_i,
  input  logic                        valid_i,
  output logic                        wb_valid_o,
  input  logic                        wb_ready_i,
  output logic [RD_W-1:0]             wb_rd_o,
  output logic [XLEN-1:0]             wb_data_o
);

  md_issue_fsm_e          state_q, state_d;
  logic [F3_W-1:0]        funct3_q;
  logic [RD_W-1:0]        rd_q;
  logic [XLEN-1:0]        op_a_q, op_b_q, result_q;
  logic [1:0][IMD_W-1:0]  imd_val_q;
  logic                   accept, result_we, is_div;

  // The timing-mode hint is consumed by the multdiv unit directly.
  logic unused_data_ind_timing;
  assign unused_data_ind_timing = data_ind_timing_i;

  assign is_div        = funct3_q[2];
  assign op_a_o        = op_a_q;
  assign op_b_o        = op_b_q;
  assign wb_rd_o       = rd_q;
  assign imd_val_q_o   = imd_val_q;

  // funct3 decode from the latched copy, stable for the whole operation.
  always_comb begin
    operator_o    = MD_OP_MULL;
    signed_mode_o = 2'b00;
    case (funct3_q)
      F3_MUL:    begin operator_o = MD_OP_MULL; signed_mode_o = 2'b00; end
      F3_MULH:   begin operator_o = MD_OP_MULH; signed_mode_o = 2'b11; end
      F3_MULHSU: begin operator_o = MD_OP_MULH; signed_mode_o = 2'b01; end
      F3_MULHU:  begin operator_o = MD_OP_MULH; signed_mode_o = 2'b00; end
      F3_DIV:    begin operator_o = MD_OP_DIV;  signed_mode_o = 2'b11; end
      F3_DIVU:   begin operator_o = MD_OP_DIV;  signed_mode_o = 2'b00; end
      F3_REM:    begin operator_o = MD_OP_REM;  signed_mode_o = 2'b11; end
      F3_REMU:   begin operator_o = MD_OP_REM;  signed_mode_o = 2'b00; end
      default:   begin operator_o = MD_OP_MULL; signed_mode_o = 2'b00; end
    endcase
  end

  // Next-state and control outputs.
  always_comb begin
    state_d            = state_q;
    req_ready_o        = 1'b0;
    mult_en_o          = 1'b0;
    div_en_o           = 1'b0;
    mult_sel_o         = 1'b0;
    div_sel_o          = 1'b0;
    multdiv_ready_id_o = 1'b0;
    wb_valid_o         = 1'b0;
    wb_data_o          = result_q;
    accept             = 1'b0;
    result_we          = 1'b0;

    case (state_q)
      IDLE: begin
        req_ready_o = ~kill_i;
        if (req_valid_i && !kill_i) begin
          accept  = 1'b1;
          state_d = BUSY;
        end
      end

      BUSY: begin
        mult_en_o  = ~is_div;
        mult_sel_o = ~is_div;
        div_en_o   = is_div;
        div_sel_o  = is_div;
        // In bypass mode a kill also releases the unit so the flush cannot stall.
        multdiv_ready_id_o = WbBypass ? (wb_ready_i | kill_i) : 1'b1;
        if (kill_i) begin
          state_d = valid_i ? IDLE : DRAIN;
        end else if (valid_i) begin
          if (WbBypass) begin
            wb_valid_o = 1'b1;
            wb_data_o  = multdiv_result_i;
            if (wb_ready_i) state_d = IDLE;
          end else begin
            result_we = 1'b1;
            state_d   = RESP;
          end
        end
      end

      DRAIN: begin
        mult_en_o          = ~is_div;
        mult_sel_o         = ~is_div;
        div_en_o           = is_div;
        div_sel_o          = is_div;
        multdiv_ready_id_o = 1'b1;
        if (valid_i) state_d = IDLE;
      end

      RESP: begin
        wb_valid_o = 1'b1;
        if (kill_i || wb_ready_i) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // State, request and result registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      funct3_q <= '0;
      rd_q     <= '0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        funct3_q <= req_funct3_i;
        rd_q     <= req_rd_i;
        op_a_q   <= req_op_a_i;
        op_b_q   <= req_op_b_i;
      end
      if (result_we) result_q <= multdiv_result_i;
    end
  end

  // Intermediate registers written by the multdiv unit only while it is enabled.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      imd_val_q <= '0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (imd_val_we_i[k] && (mult_en_o || div_en_o)) imd_val_q[k] <= imd_val_d_i[k];
      end
    end
  end

endmodule

// File: tb/tb_buraq_multdiv_issue.sv
// Directed bench for buraq_multdiv_issue: instance 0 with WbBypass=0,
// instance 1 with WbBypass=1, each driven by a behavioural multdiv unit.
module tb_buraq_multdiv_issue;
  import buraq_multdiv_issue_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              req_valid   [2];
  logic              req_ready   [2];
  logic [2:0]        req_funct3  [2];
  logic [31:0]       req_op_a    [2];
  logic [31:0]       req_op_b    [2];
  logic [4:0]        req_rd      [2];
  logic              kill        [2];
  logic              mult_en     [2];
  logic              div_en      [2];
  logic              mult_sel    [2];
  logic              div_sel     [2];
  md_op_e            op_o        [2];
  logic [1:0]        sm          [2];
  logic [31:0]       op_a_o      [2];
  logic [31:0]       op_b_o      [2];
  logic [1:0][33:0]  imd_q       [2];
  logic [33:0]       imd_pat     [2];
  logic              ready_id    [2];
  logic [31:0]       md_res      [2];
  logic              md_valid    [2];
  logic              wb_valid    [2];
  logic              wb_ready    [2];
  logic [4:0]        wb_rd       [2];
  logic [31:0]       wb_data     [2];
  int                md_cnt      [2];
  int                xfers       [2];
  int                lat         [2];
  logic              dit = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    buraq_multdiv_issue #(.WbBypass(g == 1)) u_dut (
      .clk_i              (clk),
      .rst_ni             (rst_n),
      .req_valid_i        (req_valid[g]),
      .req_ready_o        (req_ready[g]),
      .req_funct3_i       (req_funct3[g]),
      .req_op_a_i         (req_op_a[g]),
      .req_op_b_i         (req_op_b[g]),
      .req_rd_i           (req_rd[g]),
      .kill_i             (kill[g]),
      .data_ind_timing_i  (dit),
      .mult_en_o          (mult_en[g]),
      .div_en_o           (div_en[g]),
      .mult_sel_o         (mult_sel[g]),
      .div_sel_o          (div_sel[g]),
      .operator_o         (op_o[g]),
      .signed_mode_o      (sm[g]),
      .op_a_o             (op_a_o[g]),
      .op_b_o             (op_b_o[g]),
      .imd_val_q_o        (imd_q[g]),
      .imd_val_d_i        ({imd_pat[g], imd_pat[g]}),
      .imd_val_we_i       (2'b01),
      .multdiv_ready_id_o (ready_id[g]),
      .multdiv_result_i   (md_res[g]),
      .valid_i            (md_valid[g]),
      .wb_valid_o         (wb_valid[g]),
      .wb_ready_i         (wb_ready[g]),
      .wb_rd_o            (wb_rd[g]),
      .wb_data_o          (wb_data[g])
    );
  end

  // Reference RV32M arithmetic for the behavioural multdiv unit.
  function automatic logic [31:0] md_calc(input md_op_e op, input logic [1:0] s,
                                          input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ax, bx, p;
    logic        sgn, ovf;
    ax  = s[0] ? {{32{a[31]}}, a} : {32'h0, a};
    bx  = s[1] ? {{32{b[31]}}, b} : {32'h0, b};
    p   = ax * bx;
    sgn = (s == 2'b11);
    ovf = sgn && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      MD_OP_MULL: return p[31:0];
      MD_OP_MULH: return p[63:32];
      MD_OP_DIV: begin
        if (b == 32'h0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        return sgn ? 32'($signed(a) / $signed(b)) : a / b;
      end
      default: begin
        if (b == 32'h0) return a;
        if (ovf) return 32'h0;
        return sgn ? 32'($signed(a) % $signed(b)) : a % b;
      end
    endcase
  endfunction

  // Behavioural multdiv unit: result valid after lat enabled cycles, held
  // until the controller lets it leave; also counts writeback transfers.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int g = 0; g < 2; g++) begin
        md_valid[g] <= 1'b0;
        md_cnt[g]   <= 0;
        md_res[g]   <= 32'h0;
        xfers[g]    <= 0;
      end
    end else begin
      for (int g = 0; g < 2; g++) begin
        if (wb_valid[g] && wb_ready[g]) xfers[g] <= xfers[g] + 1;
        if (!(mult_en[g] || div_en[g])) begin
          md_valid[g] <= 1'b0;
          md_cnt[g]   <= 0;
        end else if (md_valid[g]) begin
          if (ready_id[g]) begin
            md_valid[g] <= 1'b0;
            md_cnt[g]   <= 0;
          end
        end else if (md_cnt[g] == lat[g] - 1) begin
          md_valid[g] <= 1'b1;
          md_res[g]   <= md_calc(op_o[g], sm[g], op_a_o[g], op_b_o[g]);
        end else begin
          md_cnt[g] <= md_cnt[g] + 1;
        end
      end
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One request through to its writeback transfer, stalling writeback for
  // 'stall' cycles once the result is offered.
  task automatic run_op(input int g, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp, input int stall);
    int k;
    int x0;
    @(negedge clk);
    x0 = xfers[g];
    check_eq("idle_ready", req_ready[g], 1);
    req_valid[g]  = 1'b1;
    req_funct3[g] = f3;
    req_op_a[g]   = a;
    req_op_b[g]   = b;
    req_rd[g]     = rd;
    wb_ready[g]   = 1'b0;
    @(negedge clk);
    req_valid[g] = 1'b0;
    req_op_a[g]  = 32'h0;
    req_op_b[g]  = 32'h0;
    req_rd[g]    = 5'h0;
    check_eq("busy_ready", req_ready[g], 0);
    check_eq("mult_en", mult_en[g], !f3[2]);
    check_eq("div_sel", div_sel[g], f3[2]);
    check_eq("op_a", op_a_o[g], a);
    check_eq("op_b", op_b_o[g], b);
    k = 1;
    while (!wb_valid[g]) begin
      if (k > 200) begin
        check_eq("wb_timeout", wb_valid[g], 1);
        return;
      end
      if (req_ready[g]) check_eq("ready_in_op", req_ready[g], 0);
      @(negedge clk);
      k++;
    end
    check_eq("latency", k, 1 + lat[g] + ((g == 0) ? 1 : 0));
    for (int s = 0; s <= stall; s++) begin
      check_eq("wb_valid", wb_valid[g], 1);
      check_eq("wb_data", wb_data[g], exp);
      check_eq("wb_rd", wb_rd[g], rd);
      if (s < stall) begin
        if (g == 1) begin
          check_eq("hold_ready_id", ready_id[g], 0);
          check_eq("hold_en", mult_en[g] | div_en[g], 1);
        end
        @(negedge clk);
      end
    end
    wb_ready[g] = 1'b1;
    @(negedge clk);
    wb_ready[g] = 1'b0;
    check_eq("post_wb_valid", wb_valid[g], 0);
    check_eq("post_ready", req_ready[g], 1);
    check_eq("one_transfer", xfers[g], x0 + 1);
  endtask

  initial begin
    int k;
    int x0;
    for (int g = 0; g < 2; g++) begin
      req_valid[g]  = 1'b0;
      req_funct3[g] = 3'h0;
      req_op_a[g]   = 32'h0;
      req_op_b[g]   = 32'h0;
      req_rd[g]     = 5'h0;
      kill[g]       = 1'b0;
      wb_ready[g]   = 1'b0;
      lat[g]        = 3;
      imd_pat[g]    = 34'h2_AAAA_5555;
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state for both instances.
    for (int g = 0; g < 2; g++) begin
      check_eq("rst_ready", req_ready[g], 1);
      check_eq("rst_en", {mult_en[g], div_en[g], mult_sel[g], div_sel[g]}, 0);
      check_eq("rst_op", {op_o[g], sm[g]}, 0);
      check_eq("rst_operands", {op_a_o[g], op_b_o[g]}, 0);
      check_eq("rst_ready_id", ready_id[g], 0);
      check_eq("rst_wb", {wb_valid[g], wb_rd[g], wb_data[g]}, 0);
      check_eq("rst_imd0", imd_q[g][0], 0);
      check_eq("rst_imd1", imd_q[g][1], 0);
    end
    kill[0] = 1'b1;
    @(negedge clk);
    check_eq("idle_kill_ready", req_ready[0], 0);
    kill[0] = 1'b0;

    // Arithmetic through the non-bypass instance.
    run_op(0, 3'b000, 32'd3, 32'd5, 5'd5, 32'h0000_000F, 0);
    check_eq("imd0_written", imd_q[0][0], 34'h2_AAAA_5555);
    check_eq("imd1_no_we", imd_q[0][1], 0);
    imd_pat[0] = 34'h1_2345_6789;
    repeat (2) @(negedge clk);
    check_eq("imd0_hold_idle", imd_q[0][0], 34'h2_AAAA_5555);
    run_op(0, 3'b100, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFD, 0);
    run_op(0, 3'b110, 32'hFFFF_FFF9, 32'd2, 5'd7, 32'hFFFF_FFFF, 0);
    run_op(0, 3'b101, 32'd77, 32'd0, 5'd8, 32'hFFFF_FFFF, 0);
    run_op(0, 3'b110, 32'h1234_5678, 32'd0, 5'd9, 32'h1234_5678, 0);
    run_op(0, 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd10, 32'hFFFF_FFFE, 0);
    run_op(0, 3'b010, 32'hFFFF_FFFF, 32'd2, 5'd11, 32'hFFFF_FFFF, 0);
    run_op(0, 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd12, 32'h0000_0000, 0);

    // Kill 4 cycles into a DIV: drain until valid, no writeback.
    lat[0] = 10;
    @(negedge clk);
    x0 = xfers[0];
    req_valid[0] = 1'b1; req_funct3[0] = 3'b100;
    req_op_a[0] = 32'd100; req_op_b[0] = 32'd7; req_rd[0] = 5'd3;
    @(negedge clk);
    req_valid[0] = 1'b0;
    repeat (3) @(negedge clk);
    kill[0] = 1'b1;
    @(negedge clk);
    kill[0] = 1'b0;
    check_eq("drain_en", div_en[0], 1);
    check_eq("drain_ready_id", ready_id[0], 1);
    check_eq("drain_ready", req_ready[0], 0);
    @(negedge clk);
    kill[0] = 1'b1;
    @(negedge clk);
    kill[0] = 1'b0;
    k = 0;
    while (!md_valid[0] && k < 100) begin
      if (wb_valid[0]) check_eq("drain_wb_valid", wb_valid[0], 0);
      @(negedge clk);
      k++;
    end
    check_eq("drain_valid_seen", md_valid[0], 1);
    check_eq("drain_en_at_valid", div_en[0], 1);
    check_eq("drain_no_wb", wb_valid[0], 0);
    @(negedge clk);
    check_eq("drain_back_idle", req_ready[0], 1);
    check_eq("drain_en_off", div_en[0], 0);
    check_eq("drain_no_xfer", xfers[0], x0);
    lat[0] = 3;
    run_op(0, 3'b000, 32'd7, 32'd6, 5'd13, 32'd42, 0);

    // Writeback stall, non-bypass then bypass.
    lat[0] = 4;
    run_op(0, 3'b100, 32'd100, 32'd7, 5'd14, 32'd14, 5);
    lat[1] = 1;
    run_op(1, 3'b000, 32'd3, 32'd5, 5'd15, 32'h0000_000F, 0);
    lat[1] = 2;
    run_op(1, 3'b100, 32'hFFFF_FFF9, 32'd2, 5'd16, 32'hFFFF_FFFD, 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
